// File: rtl/byte_add_dma_pkg.sv
// Shared types and lane arithmetic for the byte_add_dma engine.
package byte_add_dma_pkg;

  localparam int unsigned MAX_LANES = 128;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  function automatic logic [7:0] byte_op(input logic [7:0] b, input logic [7:0] addend,
                                         input logic sat);
    logic [8:0] sum;
    sum = {1'b0, b} + {1'b0, addend};
    return (sat && sum[8]) ? 8'hFF : sum[7:0];
  endfunction

  // Mask for the final word: low m lanes, or all lanes if the job was clipped or word-aligned.
  function automatic logic [MAX_LANES-1:0] last_be(input logic [7:0] m, input logic clipped);
    if (clipped || m == 8'd0) return '1;
    return (MAX_LANES'(1) << m) - MAX_LANES'(1);
  endfunction

endpackage

// File: rtl/byte_add_dma_fifo.sv
// Elastic buffer between read returns and the registered write stage.
module byte_add_dma_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && (count_q != (AW+1)'(DEPTH));
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/byte_add_dma.sv
// In-place per-byte add engine over Avalon-MM read/write masters.
// Define BYTE_ADD_DMA_STATS_EN to add the stat_words_o / stat_sat_o counters.
module byte_add_dma
  import byte_add_dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BYTE_CNT   = DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  run_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] length_i,
  input  logic [7:0]            addend_i,
  input  logic                  sat_i,
  output logic                  waitrequest_o,
  output logic [ADDR_WIDTH-1:0] amm_rd_address_o,
  output logic                  amm_rd_read_o,
  input  logic [DATA_WIDTH-1:0] amm_rd_readdata_i,
  input  logic                  amm_rd_readdatavalid_i,
  input  logic                  amm_rd_waitrequest_i,
  output logic [ADDR_WIDTH-1:0] amm_wr_address_o,
  output logic                  amm_wr_write_o,
  output logic [DATA_WIDTH-1:0] amm_wr_writedata_o,
  output logic [BYTE_CNT-1:0]   amm_wr_byteenable_o,
  input  logic                  amm_wr_waitrequest_i
`ifdef BYTE_ADD_DMA_STATS_EN
  ,
  output logic [ADDR_WIDTH:0]   stat_words_o,
  output logic [15:0]           stat_sat_o
`endif
);

  localparam int unsigned CW = $clog2(MAX_OUTST);
  localparam int unsigned XW = ADDR_WIDTH + 2;
  localparam int unsigned NW = ADDR_WIDTH + 1;
  localparam logic [XW-1:0] BC_X    = XW'(BYTE_CNT);
  localparam logic [XW-1:0] SPACE_X = XW'(1) << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [NW-1:0]         words_q, words_d;
  logic [7:0]            rem_q, rem_d;
  logic                  clip_q, clip_d;
  logic [7:0]            addend_q, addend_d;
  logic                  sat_q, sat_d;
  logic [NW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [NW-1:0]         ld_cnt_q, ld_cnt_d;
  logic [CW:0]           in_flight_q, in_flight_d;
  logic                  wr_valid_q, wr_valid_d;
  logic                  wr_last_q, wr_last_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [BYTE_CNT-1:0]   wr_be_q, wr_be_d;

  logic [XW-1:0]         len_x, base_x, words_raw;
  logic [NW-1:0]         words_n;
  logic                  clip_n;
  logic                  run_acc, credit, rd_req, rd_acc, rv_ok, wr_acc, load, ld_last;
  logic [BYTE_CNT-1:0]   ld_be;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic [CW:0]           fifo_cnt;

  byte_add_dma_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (MAX_OUTST)
  ) u_fifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .push_i   (rv_ok),
    .data_i   (amm_rd_readdata_i),
    .pop_i    (load),
    .data_o   (fifo_dout),
    .empty_o  (fifo_empty),
    .count_o  (fifo_cnt)
  );

  always_comb begin
    len_x     = XW'(length_i);
    base_x    = XW'(base_addr_i);
    words_raw = (len_x + BC_X - XW'(1)) / BC_X;
    clip_n    = (base_x + words_raw) > SPACE_X;
    words_n   = clip_n ? NW'(SPACE_X - base_x) : NW'(words_raw);
  end

  // Reads in flight plus buffered words never exceed the buffer depth, so pushes cannot overflow.
  always_comb begin
    run_acc = (state_q == IDLE) && run_i && (length_i != '0);
    credit  = ({1'b0, in_flight_q} + {1'b0, fifo_cnt}) < (CW+2)'(MAX_OUTST);
    rd_req  = (state_q == XFER) && (rd_cnt_q < words_q) && credit;
    rd_acc  = rd_req && !amm_rd_waitrequest_i;
    rv_ok   = amm_rd_readdatavalid_i && (in_flight_q != '0);
    wr_acc  = wr_valid_q && !amm_wr_waitrequest_i;
    load    = (state_q == XFER) && !fifo_empty && (!wr_valid_q || wr_acc);
    ld_last = (ld_cnt_q == words_q - NW'(1));
    ld_be   = ld_last ? BYTE_CNT'(last_be(rem_q, clip_q)) : '1;
  end

  always_comb begin
    ld_data = '0;
    for (int unsigned k = 0; k < BYTE_CNT; k++) begin
      ld_data[8*k +: 8] = byte_op(fifo_dout[8*k +: 8], addend_q, sat_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    words_d     = words_q;
    rem_d       = rem_q;
    clip_d      = clip_q;
    addend_d    = addend_q;
    sat_d       = sat_q;
    rd_cnt_d    = rd_cnt_q;
    ld_cnt_d    = ld_cnt_q;
    in_flight_d = in_flight_q;
    wr_valid_d  = wr_valid_q;
    wr_last_d   = wr_last_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_be_d     = wr_be_q;
    unique case (state_q)
      IDLE: begin
        if (run_acc) begin
          base_d      = base_addr_i;
          words_d     = words_n;
          rem_d       = 8'(len_x % BC_X);
          clip_d      = clip_n;
          addend_d    = addend_i;
          sat_d       = sat_i;
          rd_cnt_d    = '0;
          ld_cnt_d    = '0;
          in_flight_d = '0;
          state_d     = XFER;
        end
      end
      XFER: begin
        rd_cnt_d    = rd_cnt_q + NW'(rd_acc);
        in_flight_d = in_flight_q + (CW+1)'(rd_acc) - (CW+1)'(rv_ok);
        if (load) begin
          wr_valid_d = 1'b1;
          wr_last_d  = ld_last;
          wr_addr_d  = base_q + ld_cnt_q[ADDR_WIDTH-1:0];
          wr_data_d  = ld_data;
          wr_be_d    = ld_be;
          ld_cnt_d   = ld_cnt_q + NW'(1);
        end else if (wr_acc) begin
          wr_valid_d = 1'b0;
        end
        if (wr_acc && wr_last_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= IDLE;
      base_q      <= '0;
      words_q     <= '0;
      rem_q       <= '0;
      clip_q      <= 1'b0;
      addend_q    <= '0;
      sat_q       <= 1'b0;
      rd_cnt_q    <= '0;
      ld_cnt_q    <= '0;
      in_flight_q <= '0;
      wr_valid_q  <= 1'b0;
      wr_last_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_be_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      words_q     <= words_d;
      rem_q       <= rem_d;
      clip_q      <= clip_d;
      addend_q    <= addend_d;
      sat_q       <= sat_d;
      rd_cnt_q    <= rd_cnt_d;
      ld_cnt_q    <= ld_cnt_d;
      in_flight_q <= in_flight_d;
      wr_valid_q  <= wr_valid_d;
      wr_last_q   <= wr_last_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_be_q     <= wr_be_d;
    end
  end

  assign waitrequest_o       = (state_q != IDLE);
  assign amm_rd_read_o       = rd_req;
  assign amm_rd_address_o    = base_q + rd_cnt_q[ADDR_WIDTH-1:0];
  assign amm_wr_write_o      = wr_valid_q;
  assign amm_wr_address_o    = wr_addr_q;
  assign amm_wr_writedata_o  = wr_data_q;
  assign amm_wr_byteenable_o = wr_be_q;

`ifdef BYTE_ADD_DMA_STATS_EN
  logic [ADDR_WIDTH:0] stat_words_q, stat_words_d;
  logic [15:0]         stat_sat_q, stat_sat_d, sat_lanes;

  // Clamped lanes are counted when a word enters the write stage.
  always_comb begin
    sat_lanes = '0;
    for (int unsigned k = 0; k < BYTE_CNT; k++) begin
      if (ld_be[k] && sat_q && (({1'b0, fifo_dout[8*k +: 8]} + {1'b0, addend_q}) > 9'h0FF))
        sat_lanes = sat_lanes + 16'd1;
    end
    stat_words_d = stat_words_q;
    stat_sat_d   = stat_sat_q;
    if (run_acc) begin
      stat_words_d = '0;
      stat_sat_d   = '0;
    end else begin
      if (wr_acc) stat_words_d = stat_words_q + NW'(1);
      if (load)   stat_sat_d   = stat_sat_q + sat_lanes;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      stat_words_q <= '0;
      stat_sat_q   <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_sat_q   <= stat_sat_d;
    end
  end

  assign stat_words_o = stat_words_q;
  assign stat_sat_o   = stat_sat_q;
`endif

endmodule

// File: tb/tb_byte_add_dma.sv
// Directed bench for byte_add_dma with a behavioural Avalon memory slave.
module tb_byte_add_dma;

  logic        clk = 1'b0;
  logic        arst_n_i;
  logic        run_i;
  logic [9:0]  base_addr_i;
  logic [9:0]  length_i;
  logic [7:0]  addend_i;
  logic        sat_i;
  logic        waitrequest_o;
  logic [9:0]  amm_rd_address_o;
  logic        amm_rd_read_o;
  logic [63:0] amm_rd_readdata_i;
  logic        amm_rd_readdatavalid_i;
  logic        amm_rd_waitrequest_i;
  logic [9:0]  amm_wr_address_o;
  logic        amm_wr_write_o;
  logic [63:0] amm_wr_writedata_o;
  logic [7:0]  amm_wr_byteenable_o;
  logic        amm_wr_waitrequest_i;

  byte_add_dma dut (
    .clk_i                  (clk),
    .arst_n_i               (arst_n_i),
    .run_i                  (run_i),
    .base_addr_i            (base_addr_i),
    .length_i               (length_i),
    .addend_i               (addend_i),
    .sat_i                  (sat_i),
    .waitrequest_o          (waitrequest_o),
    .amm_rd_address_o       (amm_rd_address_o),
    .amm_rd_read_o          (amm_rd_read_o),
    .amm_rd_readdata_i      (amm_rd_readdata_i),
    .amm_rd_readdatavalid_i (amm_rd_readdatavalid_i),
    .amm_rd_waitrequest_i   (amm_rd_waitrequest_i),
    .amm_wr_address_o       (amm_wr_address_o),
    .amm_wr_write_o         (amm_wr_write_o),
    .amm_wr_writedata_o     (amm_wr_writedata_o),
    .amm_wr_byteenable_o    (amm_wr_byteenable_o),
    .amm_wr_waitrequest_i   (amm_wr_waitrequest_i)
  );

  always #5 clk = ~clk;

  typedef struct {logic [9:0] addr; int due;} rd_t;
  typedef struct {logic [9:0] addr; logic [7:0] be; logic [63:0] data;} wr_t;

  logic [63:0] mem [1024];
  rd_t         rq[$];
  logic [9:0]  rlog[$];
  wr_t         wlog[$];
  int          cyc = 0, lat = 1, max_outst = 0, outst = 0, viol = 0;
  int          n_assert = 0, n_fail = 0;
  bit          rd_rand = 0, wr_pat = 0, mon_outst = 0, inject_rv = 0, touched0 = 0;
  bit          prev_rd_stall = 0, prev_wr_stall = 0;
  logic [9:0]  prev_rd_addr, prev_wr_addr;
  logic [63:0] prev_wr_data;
  logic [7:0]  prev_wr_be;

  function automatic logic [63:0] pat(input int a);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'(a * 7 + k * 37 + 3);
    return r;
  endfunction

  function automatic logic [63:0] exp_word(input logic [63:0] orig, input logic [7:0] add,
                                           input logic s, input logic [7:0] be);
    logic [63:0] r;
    logic [8:0]  t;
    for (int k = 0; k < 8; k++) begin
      t = {1'b0, orig[8*k +: 8]} + {1'b0, add};
      r[8*k +: 8] = !be[k] ? orig[8*k +: 8] : ((s && t[8]) ? 8'hFF : t[7:0]);
    end
    return r;
  endfunction

  // Slave model: drives its inputs for the coming rising edge and logs accepted transfers.
  always @(negedge clk) begin
    cyc++;
    if (mon_outst) begin
      outst = rlog.size() - wlog.size() - int'(amm_wr_write_o);
      if (outst > max_outst) max_outst = outst;
    end
    amm_rd_readdatavalid_i = 1'b0;
    amm_rd_readdata_i      = '0;
    if (rq.size() != 0 && rq[0].due <= cyc) begin
      amm_rd_readdatavalid_i = 1'b1;
      amm_rd_readdata_i      = mem[rq[0].addr];
      rq.delete(0);
    end
    if (inject_rv) begin
      amm_rd_readdatavalid_i = 1'b1;
      amm_rd_readdata_i      = 64'hDEAD_BEEF_0BAD_F00D;
    end
    amm_rd_waitrequest_i = rd_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    amm_wr_waitrequest_i = wr_pat ? 1'((cyc >> 1) & 1) : 1'b0;
    if (!arst_n_i) begin
      prev_rd_stall = 0;
      prev_wr_stall = 0;
    end else begin
      if (prev_rd_stall && (!amm_rd_read_o || amm_rd_address_o != prev_rd_addr)) viol++;
      if (prev_wr_stall && (!amm_wr_write_o || amm_wr_address_o != prev_wr_addr ||
          amm_wr_writedata_o != prev_wr_data || amm_wr_byteenable_o != prev_wr_be)) viol++;
      if (amm_rd_read_o && !amm_rd_waitrequest_i) begin
        rq.push_back('{addr: amm_rd_address_o, due: cyc + lat});
        rlog.push_back(amm_rd_address_o);
        if (amm_rd_address_o == 10'h000) touched0 = 1;
      end
      if (amm_wr_write_o && !amm_wr_waitrequest_i) begin
        for (int k = 0; k < 8; k++)
          if (amm_wr_byteenable_o[k]) mem[amm_wr_address_o][8*k +: 8] = amm_wr_writedata_o[8*k +: 8];
        wlog.push_back('{addr: amm_wr_address_o, be: amm_wr_byteenable_o, data: amm_wr_writedata_o});
        if (amm_wr_address_o == 10'h000) touched0 = 1;
      end
      prev_rd_stall = amm_rd_read_o && amm_rd_waitrequest_i;
      prev_rd_addr  = amm_rd_address_o;
      prev_wr_stall = amm_wr_write_o && amm_wr_waitrequest_i;
      prev_wr_addr  = amm_wr_address_o;
      prev_wr_data  = amm_wr_writedata_o;
      prev_wr_be    = amm_wr_byteenable_o;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    rlog.delete();
    wlog.delete();
    touched0 = 0;
  endtask

  task automatic start(input logic [9:0] b, input logic [9:0] l, input logic [7:0] a, input logic s);
    base_addr_i = b;
    length_i    = l;
    addend_i    = a;
    sat_i       = s;
    run_i       = 1'b1;
    tick();
    run_i       = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (waitrequest_o === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, waitrequest_o, 1'b0);
  endtask

  initial begin
    bit busy;
    arst_n_i = 1'b0;
    run_i = 1'b0; base_addr_i = '0; length_i = '0; addend_i = '0; sat_i = 1'b0;
    amm_rd_readdata_i = '0; amm_rd_readdatavalid_i = 1'b0;
    amm_rd_waitrequest_i = 1'b0; amm_wr_waitrequest_i = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = pat(a);
    #1;
    chk("rst_wait", waitrequest_o, 1'b0);
    chk("rst_rd", amm_rd_read_o, 1'b0);
    chk("rst_wr", amm_wr_write_o, 1'b0);
    chk("rst_wdata", amm_wr_writedata_o, 64'h0);
    tick(); tick();
    arst_n_i = 1'b1;
    tick();

    // Basic job: 21 bytes from 0x10, wrap add 1.
    clr();
    start(10'h010, 10'd21, 8'd1, 1'b0);
    chk("t1_busy", waitrequest_o, 1'b1);
    chk("t1_first_rd", amm_rd_read_o, 1'b1);
    chk("t1_first_addr", amm_rd_address_o, 10'h010);
    wait_idle("t1_done", 200);
    chk("t1_nrd", rlog.size(), 3);
    chk("t1_rd2", rlog[2], 10'h012);
    chk("t1_nwr", wlog.size(), 3);
    chk("t1_wa0", wlog[0].addr, 10'h010);
    chk("t1_wa2", wlog[2].addr, 10'h012);
    chk("t1_be0", wlog[0].be, 8'hFF);
    chk("t1_be1", wlog[1].be, 8'hFF);
    chk("t1_be2", wlog[2].be, 8'h1F);
    chk("t1_m10", mem[10'h010], exp_word(pat(10'h010), 8'd1, 1'b0, 8'hFF));
    chk("t1_m11", mem[10'h011], exp_word(pat(10'h011), 8'd1, 1'b0, 8'hFF));
    chk("t1_m12", mem[10'h012], exp_word(pat(10'h012), 8'd1, 1'b0, 8'h1F));

    // Arithmetic modes on a hand-picked word.
    clr();
    mem[10'h020] = 64'h2f1eff16ff12ffee;
    start(10'h020, 10'd7, 8'd1, 1'b0);
    wait_idle("t2w_done", 200);
    chk("t2w_be", wlog[0].be, 8'h7F);
    chk("t2w_mem", mem[10'h020], 64'h2f1f0017001300ef);
    clr();
    mem[10'h020] = 64'h2f1eff16ff12ffee;
    start(10'h020, 10'd7, 8'd1, 1'b1);
    wait_idle("t2s_done", 200);
    chk("t2s_mem", mem[10'h020], 64'h2f1fff17ff13ffef);
    clr();
    mem[10'h021] = 64'h01FE7F800000FA10;
    start(10'h021, 10'd8, 8'd5, 1'b1);
    wait_idle("t2s5_done", 200);
    chk("t2s5_mem", mem[10'h021], 64'h06FF84850505FF15);

    // Top-of-space clip.
    clr();
    start(10'h3FC, 10'd45, 8'd1, 1'b0);
    wait_idle("t3_done", 200);
    chk("t3_nrd", rlog.size(), 4);
    chk("t3_nwr", wlog.size(), 4);
    chk("t3_rd3", rlog[3], 10'h3FF);
    chk("t3_wa3", wlog[3].addr, 10'h3FF);
    chk("t3_be3", wlog[3].be, 8'hFF);
    chk("t3_no0", touched0, 1'b0);

    // Backpressure on both sides with read latency 3.
    clr();
    lat = 3; rd_rand = 1; wr_pat = 1; max_outst = 0; viol = 0; mon_outst = 1;
    start(10'h040, 10'd50, 8'd3, 1'b0);
    wait_idle("t4_done", 600);
    mon_outst = 0;
    chk("t4_nwr", wlog.size(), 7);
    chk("t4_be6", wlog[6].be, 8'h03);
    chk("t4_outst", max_outst <= 4, 1'b1);
    chk("t4_stable", viol, 0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t4_wa%0d", i), wlog[i].addr, 10'(10'h040 + i));
      chk($sformatf("t4_m%0d", i), mem[10'h040 + i],
          exp_word(pat(10'h040 + i), 8'd3, 1'b0, (i == 6) ? 8'h03 : 8'hFF));
    end

    // Reset in the middle of a job.
    clr();
    rd_rand = 0;
    start(10'h080, 10'd64, 8'd1, 1'b0);
    for (int n = 0; n < 300 && wlog.size() < 3; n++) tick();
    chk("t5_three", wlog.size(), 3);
    arst_n_i = 1'b0;
    #1;
    chk("t5_wait", waitrequest_o, 1'b0);
    chk("t5_rd", amm_rd_read_o, 1'b0);
    chk("t5_wr", amm_wr_write_o, 1'b0);
    chk("t5_ra", amm_rd_address_o, 10'h000);
    chk("t5_wa", amm_wr_address_o, 10'h000);
    chk("t5_wd", amm_wr_writedata_o, 64'h0);
    chk("t5_be", amm_wr_byteenable_o, 8'h00);
    tick(); tick();
    arst_n_i = 1'b1;
    inject_rv = 1;
    tick();
    inject_rv = 0;
    for (int n = 0; n < 15; n++) tick();
    chk("t5_late_wr", wlog.size(), 3);
    chk("t5_late_idle", waitrequest_o, 1'b0);
    clr();
    lat = 1; wr_pat = 0;
    start(10'h000, 10'd8, 8'd1, 1'b0);
    wait_idle("t5_done", 200);
    chk("t5_nrd", rlog.size(), 1);
    chk("t5_nwr", wlog.size(), 1);
    chk("t5_be_new", wlog[0].be, 8'hFF);
    chk("t5_mem", mem[10'h000], exp_word(pat(0), 8'd1, 1'b0, 8'hFF));

    // Zero length is ignored.
    clr();
    start(10'h050, 10'd0, 8'd1, 1'b0);
    busy = 0;
    for (int n = 0; n < 10; n++) begin
      busy |= waitrequest_o;
      tick();
    end
    chk("t6_len0_busy", busy, 1'b0);
    chk("t6_len0_rd", rlog.size(), 0);
    chk("t6_len0_wr", wlog.size(), 0);

    // run_i during XFER has no effect.
    clr();
    start(10'h100, 10'd16, 8'd1, 1'b0);
    tick();
    base_addr_i = 10'h200; length_i = 10'd8; run_i = 1'b1;
    tick();
    run_i = 1'b0;
    wait_idle("t6_xfer_done", 200);
    chk("t6_xfer_nwr", wlog.size(), 2);
    chk("t6_xfer_wa1", wlog[1].addr, 10'h101);
    chk("t6_xfer_nrd", rlog.size(), 2);
    for (int n = 0; n < 5; n++) tick();
    chk("t6_xfer_idle_wr", wlog.size(), 2);

    // Single byte.
    clr();
    start(10'h180, 10'd1, 8'd1, 1'b0);
    wait_idle("t6_len1_done", 200);
    chk("t6_len1_nwr", wlog.size(), 1);
    chk("t6_len1_be", wlog[0].be, 8'h01);
    chk("t6_len1_mem", mem[10'h180], exp_word(pat(10'h180), 8'd1, 1'b0, 8'h01));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
